// File: rtl/muldiv_sequencer.sv
// Iterative multiply/divide unit owning the HI/LO registers, placed beside the EX-stage ALU.
// Latency WIDTH+2 cycles from start to done (2 for divide-by-zero); stall asserted on any HI/LO access while busy.
module muldiv_sequencer #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 6
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] in1,
    input  logic [WIDTH-1:0] in2,
    input  logic             wr_hi,
    input  logic             wr_lo,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             rd_hilo,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo,
    output logic             busy,
    output logic             done,
    output logic             stall
);

    typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV, S_FIX} state_t;

    state_t               state, next_state;
    logic [CNT_W-1:0]     cnt;
    logic [WIDTH-1:0]     mcand;
    logic [2*WIDTH-1:0]   acc;
    logic                 res_neg, rem_neg, is_div;

    logic                 is_signed, in1_neg, in2_neg, div_zero;
    logic [WIDTH-1:0]     mag1, mag2;
    logic [WIDTH:0]       mul_sum, div_shift, div_diff;
    logic [2*WIDTH-1:0]   prod_fix;
    logic [WIDTH-1:0]     q_fix, r_fix;

    always_comb begin
        is_signed = ~op[0];
        in1_neg   = is_signed & in1[WIDTH-1];
        in2_neg   = is_signed & in2[WIDTH-1];
        mag1      = in1_neg ? -in1 : in1;
        mag2      = in2_neg ? -in2 : in2;
        div_zero  = op[1] && (in2 == '0);
    end

    // acc holds {partial_high, multiplier} for MUL and {remainder, quotient} for DIV
    always_comb begin
        mul_sum   = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, mcand} : '0);
        div_shift = acc[2*WIDTH-1:WIDTH-1];
        div_diff  = div_shift - {1'b0, mcand};
        prod_fix  = res_neg ? -acc : acc;
        q_fix     = res_neg ? -acc[WIDTH-1:0] : acc[WIDTH-1:0];
        r_fix     = rem_neg ? -acc[2*WIDTH-1:WIDTH] : acc[2*WIDTH-1:WIDTH];
    end

    always_ff @(posedge clk) begin
        if (reset) state <= S_IDLE;
        else       state <= next_state;
    end

    always_comb begin
        next_state = state;
        case (state)
            S_IDLE: if (start) next_state = !op[1] ? S_MUL : (div_zero ? S_FIX : S_DIV);
            S_MUL,
            S_DIV:  if (cnt == '0) next_state = S_FIX;
            S_FIX:  next_state = S_IDLE;
            default: next_state = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            hi      <= '0;
            lo      <= '0;
            done    <= 1'b0;
            cnt     <= '0;
            mcand   <= '0;
            acc     <= '0;
            res_neg <= 1'b0;
            rem_neg <= 1'b0;
            is_div  <= 1'b0;
        end else begin
            done <= (state == S_FIX);
            case (state)
                S_IDLE: begin
                    if (wr_hi) hi <= wr_data;
                    if (wr_lo) lo <= wr_data;
                    if (start) begin
                        cnt    <= CNT_W'(WIDTH-1);
                        is_div <= op[1];
                        if (div_zero) begin
                            // FIX then publishes hi=in1, lo=all ones with no sign correction
                            mcand   <= '0;
                            acc     <= {in1, {WIDTH{1'b1}}};
                            res_neg <= 1'b0;
                            rem_neg <= 1'b0;
                        end else begin
                            mcand   <= op[1] ? mag2 : mag1;
                            acc     <= {{WIDTH{1'b0}}, (op[1] ? mag1 : mag2)};
                            res_neg <= in1_neg ^ in2_neg;
                            rem_neg <= in1_neg;
                        end
                    end
                end
                S_MUL: begin
                    acc <= {mul_sum, acc[WIDTH-1:1]};
                    cnt <= cnt - 1'b1;
                end
                S_DIV: begin
                    if (!div_diff[WIDTH]) acc <= {div_diff[WIDTH-1:0], acc[WIDTH-2:0], 1'b1};
                    else                  acc <= {div_shift[WIDTH-1:0], acc[WIDTH-2:0], 1'b0};
                    cnt <= cnt - 1'b1;
                end
                S_FIX: begin
                    if (is_div) begin
                        lo <= q_fix;
                        hi <= r_fix;
                    end else begin
                        {hi, lo} <= prod_fix;
                    end
                end
                default: ;
            endcase
        end
    end

    assign busy  = (state != S_IDLE);
    assign stall = busy & (start | rd_hilo | wr_hi | wr_lo);

endmodule

// File: tb/tb_muldiv_sequencer.sv
// Directed bench for muldiv_sequencer: arithmetic results, timing, hazard stalls and reset abort.
module tb_muldiv_sequencer;

    logic        clk = 1'b0;
    logic        reset, start, wr_hi, wr_lo, rd_hilo;
    logic [1:0]  op;
    logic [31:0] in1, in2, wr_data, hi, lo;
    logic        busy, done, stall;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    muldiv_sequencer #(.WIDTH(32), .CNT_W(6)) dut (
        .clk(clk), .reset(reset), .start(start), .op(op), .in1(in1), .in2(in2),
        .wr_hi(wr_hi), .wr_lo(wr_lo), .wr_data(wr_data), .rd_hilo(rd_hilo),
        .hi(hi), .lo(lo), .busy(busy), .done(done), .stall(stall)
    );

    // Drives one op; dk is the cycle offset of done (-1 if never seen), bc counts busy cycles before it.
    task automatic run_op(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                          output logic [31:0] rh, output logic [31:0] rl,
                          output int dk, output int bc);
        @(negedge clk);
        op = o; in1 = a; in2 = b; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        dk = -1;
        bc = 0;
        for (int k = 1; k <= 100; k++) begin
            if (done) begin
                dk = k;
                break;
            end
            if (busy) bc++;
            @(negedge clk);
        end
        rh = hi;
        rl = lo;
    endtask

    task automatic test_reset();
        reset = 1'b1; start = 1'b0; op = 2'b00; in1 = '0; in2 = '0;
        wr_hi = 1'b0; wr_lo = 1'b0; wr_data = '0; rd_hilo = 1'b0;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        n_checks++; if (hi !== 32'h0)   begin n_fail++; $display("FAIL reset_hi got %h want 0", hi); end
        n_checks++; if (lo !== 32'h0)   begin n_fail++; $display("FAIL reset_lo got %h want 0", lo); end
        n_checks++; if (busy !== 1'b0)  begin n_fail++; $display("FAIL reset_busy got %b want 0", busy); end
        n_checks++; if (done !== 1'b0)  begin n_fail++; $display("FAIL reset_done got %b want 0", done); end
        n_checks++; if (stall !== 1'b0) begin n_fail++; $display("FAIL reset_stall got %b want 0", stall); end
    endtask

    task automatic test_multu();
        logic [31:0] rh, rl;
        int dk, bc;
        run_op(2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, rh, rl, dk, bc);
        n_checks++; if (rh !== 32'hFFFF_FFFE) begin n_fail++; $display("FAIL multu_hi got %h want fffffffe", rh); end
        n_checks++; if (rl !== 32'h0000_0001) begin n_fail++; $display("FAIL multu_lo got %h want 00000001", rl); end
        n_checks++; if (dk !== 34) begin n_fail++; $display("FAIL multu_done_cycle got %0d want 34", dk); end
        n_checks++; if (bc !== 33) begin n_fail++; $display("FAIL multu_busy_cycles got %0d want 33", bc); end
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL multu_busy_at_done got %b want 0", busy); end
        @(negedge clk);
        n_checks++; if (done !== 1'b0) begin n_fail++; $display("FAIL multu_done_pulse got %b want 0", done); end
    endtask

    task automatic test_mult();
        logic [31:0] rh, rl;
        int dk, bc;
        run_op(2'b00, 32'hFFFF_FFFD, 32'h0000_0005, rh, rl, dk, bc);
        n_checks++; if (rh !== 32'hFFFF_FFFF) begin n_fail++; $display("FAIL mult_neg_hi got %h want ffffffff", rh); end
        n_checks++; if (rl !== 32'hFFFF_FFF1) begin n_fail++; $display("FAIL mult_neg_lo got %h want fffffff1", rl); end
        run_op(2'b00, 32'h8000_0000, 32'h8000_0000, rh, rl, dk, bc);
        n_checks++; if (rh !== 32'h4000_0000) begin n_fail++; $display("FAIL mult_min_hi got %h want 40000000", rh); end
        n_checks++; if (rl !== 32'h0000_0000) begin n_fail++; $display("FAIL mult_min_lo got %h want 00000000", rl); end
        n_checks++; if (dk !== 34) begin n_fail++; $display("FAIL mult_done_cycle got %0d want 34", dk); end
    endtask

    task automatic test_div();
        logic [31:0] rh, rl;
        int dk, bc;
        run_op(2'b10, 32'hFFFF_FFF9, 32'h0000_0002, rh, rl, dk, bc);
        n_checks++; if (rl !== 32'hFFFF_FFFD) begin n_fail++; $display("FAIL div_neg_lo got %h want fffffffd", rl); end
        n_checks++; if (rh !== 32'hFFFF_FFFF) begin n_fail++; $display("FAIL div_neg_hi got %h want ffffffff", rh); end
        n_checks++; if (dk !== 34) begin n_fail++; $display("FAIL div_done_cycle got %0d want 34", dk); end
        run_op(2'b11, 32'h0000_0007, 32'h0000_0002, rh, rl, dk, bc);
        n_checks++; if (rl !== 32'h0000_0003) begin n_fail++; $display("FAIL divu_lo got %h want 00000003", rl); end
        n_checks++; if (rh !== 32'h0000_0001) begin n_fail++; $display("FAIL divu_hi got %h want 00000001", rh); end
        run_op(2'b10, 32'h8000_0000, 32'hFFFF_FFFF, rh, rl, dk, bc);
        n_checks++; if (rl !== 32'h8000_0000) begin n_fail++; $display("FAIL div_ovf_lo got %h want 80000000", rl); end
        n_checks++; if (rh !== 32'h0000_0000) begin n_fail++; $display("FAIL div_ovf_hi got %h want 00000000", rh); end
    endtask

    task automatic test_divzero();
        logic [31:0] rh, rl;
        int dk, bc;
        run_op(2'b11, 32'h0000_0007, 32'h0000_0000, rh, rl, dk, bc);
        n_checks++; if (rh !== 32'h0000_0007) begin n_fail++; $display("FAIL dz_hi got %h want 00000007", rh); end
        n_checks++; if (rl !== 32'hFFFF_FFFF) begin n_fail++; $display("FAIL dz_lo got %h want ffffffff", rl); end
        n_checks++; if (dk !== 2) begin n_fail++; $display("FAIL dz_done_cycle got %0d want 2", dk); end
        n_checks++; if (bc !== 1) begin n_fail++; $display("FAIL dz_busy_cycles got %0d want 1", bc); end
    endtask

    task automatic test_hazards();
        int dk, stall_bad;
        @(negedge clk);
        op = 2'b01; in1 = 32'd3; in2 = 32'd4; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        dk = -1;
        stall_bad = 0;
        for (int k = 1; k <= 100; k++) begin
            if (k == 5) begin
                start = 1'b1; op = 2'b11; in1 = 32'd100; in2 = 32'd3;
                wr_hi = 1'b1; wr_data = 32'h0000_DEAD; rd_hilo = 1'b1;
            end else if (k == 6) begin
                start = 1'b0; wr_hi = 1'b0;
            end
            #1;
            if (k >= 5 && k <= 33 && stall !== 1'b1) stall_bad++;
            if (done) begin
                dk = k;
                n_checks++; if (stall !== 1'b0) begin n_fail++; $display("FAIL hz_stall_at_done got %b want 0", stall); end
                break;
            end
            @(negedge clk);
        end
        rd_hilo = 1'b0;
        n_checks++; if (stall_bad !== 0) begin n_fail++; $display("FAIL hz_stall_window got %0d bad cycles want 0", stall_bad); end
        n_checks++; if (dk !== 34) begin n_fail++; $display("FAIL hz_done_cycle got %0d want 34", dk); end
        n_checks++; if (hi !== 32'h0) begin n_fail++; $display("FAIL hz_hi_dropped got %h want 00000000", hi); end
        n_checks++; if (lo !== 32'd12) begin n_fail++; $display("FAIL hz_lo got %h want 0000000c", lo); end
        @(negedge clk);
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL hz_start_ignored busy got %b want 0", busy); end
        wr_lo = 1'b1; wr_data = 32'h0000_1234;
        @(negedge clk);
        wr_lo = 1'b0;
        n_checks++; if (lo !== 32'h0000_1234) begin n_fail++; $display("FAIL idle_wr_lo got %h want 00001234", lo); end
    endtask

    task automatic test_wr_with_start();
        logic [31:0] rh, rl;
        int dk, bc;
        @(negedge clk);
        op = 2'b01; in1 = 32'd2; in2 = 32'd3; start = 1'b1;
        wr_hi = 1'b1; wr_data = 32'h0000_0055;
        @(negedge clk);
        start = 1'b0; wr_hi = 1'b0;
        n_checks++; if (hi !== 32'h0000_0055) begin n_fail++; $display("FAIL ws_hi_written got %h want 00000055", hi); end
        dk = -1;
        for (int k = 1; k <= 100; k++) begin
            if (done) begin dk = k; break; end
            @(negedge clk);
        end
        rh = hi; rl = lo; bc = 0;
        n_checks++; if (dk !== 34) begin n_fail++; $display("FAIL ws_done_cycle got %0d want 34", dk); end
        n_checks++; if (rh !== 32'h0) begin n_fail++; $display("FAIL ws_hi_overwritten got %h want 00000000", rh); end
        n_checks++; if (rl !== 32'd6) begin n_fail++; $display("FAIL ws_lo got %h want 00000006", rl); end
    endtask

    task automatic test_reset_mid();
        logic [31:0] rh, rl;
        int dk, bc, seen;
        @(negedge clk);
        op = 2'b00; in1 = 32'h1234_5678; in2 = 32'h0000_0100; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int k = 1; k < 10; k++) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL rm_busy got %b want 0", busy); end
        n_checks++; if (hi !== 32'h0) begin n_fail++; $display("FAIL rm_hi got %h want 00000000", hi); end
        n_checks++; if (lo !== 32'h0) begin n_fail++; $display("FAIL rm_lo got %h want 00000000", lo); end
        seen = 0;
        for (int k = 0; k < 40; k++) begin
            if (done) seen++;
            @(negedge clk);
        end
        n_checks++; if (seen !== 0) begin n_fail++; $display("FAIL rm_no_done got %0d pulses want 0", seen); end
        run_op(2'b01, 32'd6, 32'd7, rh, rl, dk, bc);
        n_checks++; if (rl !== 32'd42) begin n_fail++; $display("FAIL rm_after_lo got %h want 0000002a", rl); end
        n_checks++; if (rh !== 32'h0) begin n_fail++; $display("FAIL rm_after_hi got %h want 00000000", rh); end
        n_checks++; if (dk !== 34) begin n_fail++; $display("FAIL rm_after_done_cycle got %0d want 34", dk); end
    endtask

    initial begin
        test_reset();
        test_multu();
        test_mult();
        test_div();
        test_divzero();
        test_hazards();
        test_wr_with_start();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
